// File: rtl/mc_readout_arbiter_if.sv
// Readout bus between the internal modules, the arbiter and the MCU.
//   req         : per-module readout request (level)
//   module_data : per-module data word, stable while that module's req is high
//   mc_ack      : MCU has consumed data_to_mc
//   grant       : one-hot pulse naming the module just captured
//   cs_addr     : index of the module whose data is presented
//   data_to_mc  : registered data word for the MCU
//   data_valid  : data_to_mc holds an unconsumed word
//   timeout_err : pulse when a held word expires without mc_ack
// master = requesting modules plus MCU side, slave = the arbiter.
interface mc_readout_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 16
);
    logic [N-1:0]         req;
    logic [WIDTH-1:0]     module_data [0:N-1];
    logic                 mc_ack;
    logic [N-1:0]         grant;
    logic [$clog2(N)-1:0] cs_addr;
    logic [WIDTH-1:0]     data_to_mc;
    logic                 data_valid;
    logic                 timeout_err;

    modport master (
        output req, module_data, mc_ack,
        input  grant, cs_addr, data_to_mc, data_valid, timeout_err
    );

    modport slave (
        input  req, module_data, mc_ack,
        output grant, cs_addr, data_to_mc, data_valid, timeout_err
    );
endinterface

// File: rtl/mc_readout_arbiter.sv
// Round-robin arbiter sharing one MCU readout path between N modules.
// Captures the winning module's word into a holding register, presents it
// with data_valid until the MCU acks it or TIMEOUT held cycles expire.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : readout bus (slave side), see mc_readout_arbiter_if
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no word held; capture the round-robin winner when any req set
// HOLD   | word presented to MCU; wait for mc_ack or timeout
module mc_readout_arbiter #(
    parameter int N       = 4,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    mc_readout_arbiter_if.slave  bus
);
    localparam int AW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [AW-1:0]    cs_addr_q, cs_addr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             terr_q, terr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    last_q, last_d;

    logic             win_found;
    logic [AW-1:0]    win_idx;
    int               rr_idx;
    logic             capture;

    // Search last+1, last+2, ... modulo N so the most recent winner has
    // lowest priority. Indices are computed in int so non-power-of-two N
    // wraps correctly and never yields an index above N-1.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        rr_idx    = 0;
        for (int k = 1; k <= N; k++) begin
            rr_idx = (int'(last_q) + k) % N;
            if (!win_found && bus.req[rr_idx]) begin
                win_found = 1'b1;
                win_idx   = AW'(rr_idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = '0;
        cs_addr_d = cs_addr_q;
        data_d    = data_q;
        valid_d   = valid_q;
        terr_d    = 1'b0;
        cnt_d     = cnt_q;
        last_d    = last_q;
        capture   = 1'b0;

        case (state_q)
            S_IDLE: begin
                capture = win_found;
            end
            S_HOLD: begin
                // An ack always beats the timeout on the same edge.
                if (bus.mc_ack) begin
                    if (win_found) begin
                        capture = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    valid_d = 1'b0;
                    terr_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (capture) begin
            state_d          = S_HOLD;
            grant_d[win_idx] = 1'b1;
            cs_addr_d        = win_idx;
            data_d           = bus.module_data[win_idx];
            valid_d          = 1'b1;
            last_d           = win_idx;
            cnt_d            = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            cs_addr_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            terr_q    <= 1'b0;
            cnt_q     <= '0;
            last_q    <= AW'(N - 1);
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            cs_addr_q <= cs_addr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            terr_q    <= terr_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.cs_addr     = cs_addr_q;
    assign bus.data_to_mc  = data_q;
    assign bus.data_valid  = valid_q;
    assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_mc_readout_arbiter.sv
module tb_mc_readout_arbiter;
    localparam int N       = 4;
    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 4;

    logic clk;
    logic reset;

    mc_readout_arbiter_if #(.N(N), .WIDTH(WIDTH)) bus ();

    mc_readout_arbiter #(.N(N), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: one word holding register, round-robin pointer,
    // age counter of the held word.
    bit               m_hold;
    int               m_last;
    int               m_cnt;
    logic [N-1:0]     m_grant;
    int               m_addr;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_terr;

    task automatic model_reset();
        m_hold = 0; m_last = N - 1; m_cnt = 0;
        m_grant = '0; m_addr = 0; m_data = '0; m_valid = 0; m_terr = 0;
    endtask

    task automatic model_edge();
        int w = -1;
        m_grant = '0;
        m_terr  = 0;
        if (!m_hold || bus.mc_ack) begin
            for (int k = 1; k <= N; k++) begin
                int c = (m_last + k) % N;
                if (w < 0 && bus.req[c]) w = c;
            end
        end
        if (m_hold && !bus.mc_ack) begin
            m_cnt++;
            if (m_cnt == TIMEOUT) begin
                m_hold = 0; m_valid = 0; m_terr = 1; m_cnt = 0;
            end
        end else if (w >= 0) begin
            m_hold = 1; m_cnt = 0; m_last = w; m_addr = w;
            m_data = bus.module_data[w]; m_valid = 1; m_grant[w] = 1'b1;
        end else if (m_hold) begin
            m_hold = 0; m_valid = 0;
        end
    endtask

    task automatic check(input string tag);
        n_assert++;
        assert (bus.grant === m_grant) else begin
            n_fail++; $error("FAIL %s grant: got %b expected %b", tag, bus.grant, m_grant);
        end
        n_assert++;
        assert (bus.cs_addr === 2'(m_addr)) else begin
            n_fail++; $error("FAIL %s cs_addr: got %0d expected %0d", tag, bus.cs_addr, m_addr);
        end
        n_assert++;
        assert (bus.data_to_mc === m_data) else begin
            n_fail++; $error("FAIL %s data_to_mc: got %h expected %h", tag, bus.data_to_mc, m_data);
        end
        n_assert++;
        assert (bus.data_valid === m_valid) else begin
            n_fail++; $error("FAIL %s data_valid: got %b expected %b", tag, bus.data_valid, m_valid);
        end
        n_assert++;
        assert (bus.timeout_err === m_terr) else begin
            n_fail++; $error("FAIL %s timeout_err: got %b expected %b", tag, bus.timeout_err, m_terr);
        end
    endtask

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++; $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs are set before the call; sample one edge, advance the model,
    // compare 1ns later.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check(tag);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        #2;
        check("reset_async");
        repeat (2) @(posedge clk);
        #1;
        check("reset_held");
        expect_eq("reset_no_grant", 32'(bus.grant), 32'h0);
        reset = 1'b1;
    endtask

    initial begin
        reset       = 1'b0;
        bus.req     = '0;
        bus.mc_ack  = 1'b0;
        for (int i = 0; i < N; i++) bus.module_data[i] = 16'(16'h1000 + i);
        model_reset();

        // Reset values and first edge after release with nothing requested.
        do_reset();
        cycle("idle_no_req");

        // Single request from module 2.
        bus.req = 4'b0100;
        bus.module_data[2] = 16'hA5A5;
        cycle("single_capture");
        expect_eq("single_grant", 32'(bus.grant), 32'h4);
        expect_eq("single_addr", 32'(bus.cs_addr), 32'd2);
        expect_eq("single_data", 32'(bus.data_to_mc), 32'hA5A5);
        expect_eq("single_valid", 32'(bus.data_valid), 32'd1);
        bus.req = '0;
        bus.module_data[2] = 16'h5A5A;   // post-capture change must not leak
        cycle("single_hold");
        expect_eq("single_grant_pulse", 32'(bus.grant), 32'h0);
        expect_eq("single_data_stable", 32'(bus.data_to_mc), 32'hA5A5);
        bus.mc_ack = 1'b1;
        cycle("single_ack");
        expect_eq("single_released", 32'(bus.data_valid), 32'd0);
        expect_eq("single_addr_kept", 32'(bus.cs_addr), 32'd2);
        bus.mc_ack = 1'b0;

        // Round robin with all requesting and ack every cycle.
        do_reset();
        bus.req = 4'b1111;
        bus.mc_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle("rr_step");
            expect_eq("rr_grant_order", 32'(bus.grant), 32'(1 << (i % 4)));
            expect_eq("rr_valid", 32'(bus.data_valid), 32'd1);
        end
        bus.req = '0;
        cycle("rr_drain");
        bus.mc_ack = 1'b0;

        // Fairness after wrap: pointer at 3, modules 0 and 3 requesting.
        do_reset();
        bus.req = 4'b1001;
        cycle("fair_first");
        expect_eq("fair_first_grant", 32'(bus.grant), 32'h1);
        bus.req = 4'b1000;
        bus.mc_ack = 1'b1;
        cycle("fair_second");
        expect_eq("fair_second_grant", 32'(bus.grant), 32'h8);
        bus.req = '0;
        cycle("fair_drain");
        bus.mc_ack = 1'b0;

        // Timeout: capture module 1 and never ack.
        bus.req = 4'b0010;
        cycle("to_capture");
        bus.req = '0;
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            cycle("to_wait");
            expect_eq("to_still_valid", 32'(bus.data_valid), 32'd1);
        end
        cycle("to_expire");
        expect_eq("to_err_pulse", 32'(bus.timeout_err), 32'd1);
        expect_eq("to_valid_drop", 32'(bus.data_valid), 32'd0);
        cycle("to_after");
        expect_eq("to_err_once", 32'(bus.timeout_err), 32'd0);

        // Ack arriving on the edge the count would reach TIMEOUT.
        bus.req = 4'b0100;
        cycle("ab_capture");
        bus.req = '0;
        for (int i = 0; i < TIMEOUT - 1; i++) cycle("ab_wait");
        bus.mc_ack = 1'b1;
        cycle("ab_ack");
        expect_eq("ab_no_err", 32'(bus.timeout_err), 32'd0);
        expect_eq("ab_released", 32'(bus.data_valid), 32'd0);
        bus.mc_ack = 1'b0;

        // Reset in the middle of HOLD.
        bus.module_data[0] = 16'h1234;
        bus.req = 4'b0001;
        cycle("mid_capture");
        expect_eq("mid_data", 32'(bus.data_to_mc), 32'h1234);
        bus.req = '0;
        #3;
        do_reset();
        bus.req = 4'b0011;
        cycle("mid_after");
        expect_eq("mid_after_grant", 32'(bus.grant), 32'h1);
        bus.req = 4'b0010;
        bus.mc_ack = 1'b1;
        cycle("mid_next");
        bus.req = '0;
        bus.mc_ack = 1'b0;

        // Randomized traffic: requesters drop after grant, random new
        // requests, random acks so timeouts also occur.
        for (int t = 0; t < 400; t++) begin
            bus.req = (bus.req & ~m_grant) |
                      (($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000);
            for (int i = 0; i < N; i++)
                if (!bus.req[i]) bus.module_data[i] = 16'($urandom);
            bus.mc_ack = ($urandom_range(0, 2) == 0);
            cycle("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
